// File: rtl/rv32i_core.sv
// rv32i_core: two-stage (IF, EX) RV32I integer core.
// Unified instruction/data memory; every instruction completes in EX.

module rv32i_mem #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] ia_i,
    output logic [31:0]   id_o,
    input  logic [AW-1:0] da_i,
    output logic [31:0]   dd_o,
    input  logic [31:0]   wd_i,
    input  logic [3:0]    be_i
);
    logic [31:0] data [0:MEM_WORDS-1];

    assign id_o = data[ia_i];
    assign dd_o = data[da_i];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) data[da_i][8*b +: 8] <= wd_i[8*b +: 8];
        end
    end
endmodule

module rv32i_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] IFID_NowPC, IFID_Instr;
    logic [31:0] rf_q [0:31];

    logic [31:0] fetch, rdata, ea, wdata, wb_val, target;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [15:0] half;
    logic [7:0]  lane;
    logic [3:0]  be;
    logic        wb_en, redirect, br_tk, opi_ok, op_ok;
    logic        unused_ok;

    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) i_Dcache (
        .clk_i (clk),
        .ia_i  (pc_q[AW+1:2]),
        .id_o  (fetch),
        .da_i  (ea[AW+1:2]),
        .dd_o  (rdata),
        .wd_i  (wdata),
        .be_i  (rst ? 4'b0000 : be)
    );

    assign opc = IFID_Instr[6:0];
    assign rd  = IFID_Instr[11:7];
    assign f3  = IFID_Instr[14:12];
    assign rs1 = IFID_Instr[19:15];
    assign rs2 = IFID_Instr[24:20];
    assign f7  = IFID_Instr[31:25];

    assign imm_i = {{20{IFID_Instr[31]}}, IFID_Instr[31:20]};
    assign imm_s = {{20{IFID_Instr[31]}}, IFID_Instr[31:25], IFID_Instr[11:7]};
    assign imm_b = {{19{IFID_Instr[31]}}, IFID_Instr[31], IFID_Instr[7],
                    IFID_Instr[30:25], IFID_Instr[11:8], 1'b0};
    assign imm_u = {IFID_Instr[31:12], 12'd0};
    assign imm_j = {{11{IFID_Instr[31]}}, IFID_Instr[31], IFID_Instr[19:12],
                    IFID_Instr[20], IFID_Instr[30:21], 1'b0};

    // rf_q[0] is reset and never written, so it reads as zero
    assign rs1_v = rf_q[rs1];
    assign rs2_v = rf_q[rs2];

    assign ea   = rs1_v + ((opc == OP_STORE) ? imm_s : imm_i);
    assign lane = ea[1] ? (ea[0] ? rdata[31:24] : rdata[23:16])
                        : (ea[0] ? rdata[15:8]  : rdata[7:0]);
    assign half = ea[1] ? rdata[31:16] : rdata[15:0];
    assign unused_ok = ^{ea[31:AW+2], pc_q[1:0]};

    assign opi_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    assign op_ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, sra;
        sra = $signed(a) >>> b[4:0];
        case (f)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? sra : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        case (f3)
            3'd0:    br_tk = rs1_v == rs2_v;
            3'd1:    br_tk = rs1_v != rs2_v;
            3'd4:    br_tk = $signed(rs1_v) <  $signed(rs2_v);
            3'd5:    br_tk = $signed(rs1_v) >= $signed(rs2_v);
            3'd6:    br_tk = rs1_v <  rs2_v;
            3'd7:    br_tk = rs1_v >= rs2_v;
            default: br_tk = 1'b0;
        endcase
    end

    always_comb begin
        wb_en    = 1'b0;
        wb_val   = '0;
        redirect = 1'b0;
        target   = '0;
        be       = '0;
        wdata    = '0;
        case (opc)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = IFID_NowPC + imm_u;
            end
            OP_JAL, OP_JALR: begin
                wb_en    = 1'b1;
                wb_val   = IFID_NowPC + 32'd4;
                redirect = 1'b1;
                target   = (opc == OP_JAL) ? IFID_NowPC + imm_j : {ea[31:1], 1'b0};
            end
            OP_BR: begin
                redirect = br_tk;
                target   = IFID_NowPC + imm_b;
            end
            OP_LOAD: begin
                wb_en = 1'b1;
                case (f3)
                    3'd0:    wb_val = {{24{lane[7]}}, lane};
                    3'd1:    wb_val = {{16{half[15]}}, half};
                    3'd2:    wb_val = rdata;
                    3'd4:    wb_val = {24'd0, lane};
                    3'd5:    wb_val = {16'd0, half};
                    default: wb_en = 1'b0;
                endcase
            end
            OP_STORE: begin
                case (f3)
                    3'd0: begin
                        be    = 4'b0001 << ea[1:0];
                        wdata = {4{rs2_v[7:0]}};
                    end
                    3'd1: begin
                        be    = ea[1] ? 4'b1100 : 4'b0011;
                        wdata = {2{rs2_v[15:0]}};
                    end
                    3'd2: begin
                        be    = 4'b1111;
                        wdata = rs2_v;
                    end
                    default: be = '0;
                endcase
            end
            OP_IMM: begin
                wb_en  = opi_ok;
                wb_val = alu(f3, (f3 == 3'd5) & f7[5], rs1_v, imm_i);
            end
            OP_REG: begin
                wb_en  = op_ok;
                wb_val = alu(f3, f7[5], rs1_v, rs2_v);
            end
            default: wb_en = 1'b0;
        endcase
    end

    assign pc_d = redirect ? target : pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            IFID_NowPC <= '0;
            IFID_Instr <= NOP;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            IFID_NowPC <= pc_q;
            IFID_Instr <= redirect ? NOP : fetch;
            if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed and random programs checked against an
// instruction-level reference model (arch state plus IFID_NowPC trace).

module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_core #(.RESET_PC(32'h0), .MEM_WORDS(4096)) dut (
        .clk (clk),
        .rst (rst)
    );

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_006F;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] img [0:4095];
    logic [31:0] m   [0:4095];
    logic [31:0] r   [0:31];
    logic [31:0] pc;
    logic [31:0] exp_tr [$];
    logic [31:0] tr  [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
        input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
        input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
        input logic [11:0] imm);
        return enc_i(7'h13, rd, 3'd0, rs1, imm);
    endfunction

    function automatic logic [7:0] rd_b(input logic [31:0] a);
        return m[a[13:2]][8*a[1:0] +: 8];
    endfunction
    task automatic wr_b(input logic [31:0] a, input logic [7:0] v);
        m[a[13:2]][8*a[1:0] +: 8] = v;
    endtask
    task automatic wreg(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) r[rd] = v;
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic alt,
        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] v;
        case (f)
            3'd0: v = alt ? a + ~b + 32'd1 : a + b;
            3'd1: v = a << b[4:0];
            3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: v = (a < b) ? 32'd1 : 32'd0;
            3'd4: v = a ^ b;
            3'd5: if (alt) v = $signed(a) >>> b[4:0]; else v = a >> b[4:0];
            3'd6: v = a | b;
            default: v = a & b;
        endcase
        return v;
    endfunction

    task automatic iss_step();
        logic [31:0] ir, a, b, nxt, t, ii, is, ib, iu, ij;
        logic [15:0] h;
        logic [7:0]  v8;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        tk, ok;
        ir = m[pc[13:2]];
        rd = ir[11:7];
        f3 = ir[14:12];
        f7 = ir[31:25];
        a  = r[ir[19:15]];
        b  = r[ir[24:20]];
        ii = {{20{ir[31]}}, ir[31:20]};
        is = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        ib = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        iu = {ir[31:12], 12'd0};
        ij = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        nxt = pc + 32'd4;
        tk  = 1'b0;
        case (ir[6:0])
            7'h37: wreg(rd, iu);
            7'h17: wreg(rd, pc + iu);
            7'h6F: begin wreg(rd, pc + 32'd4); nxt = pc + ij; tk = 1'b1; end
            7'h67: begin
                t = (a + ii) & 32'hFFFF_FFFE;
                wreg(rd, pc + 32'd4);
                nxt = t;
                tk  = 1'b1;
            end
            7'h63: begin
                case (f3)
                    3'd0: ok = (a == b);
                    3'd1: ok = (a != b);
                    3'd4: ok = ($signed(a) < $signed(b));
                    3'd5: ok = ($signed(a) >= $signed(b));
                    3'd6: ok = (a < b);
                    3'd7: ok = (a >= b);
                    default: ok = 1'b0;
                endcase
                if (ok) begin nxt = pc + ib; tk = 1'b1; end
            end
            7'h03: begin
                t  = a + ii;
                v8 = rd_b(t);
                h  = {rd_b({t[31:2], t[1], 1'b1}), rd_b({t[31:2], t[1], 1'b0})};
                case (f3)
                    3'd0: wreg(rd, {{24{v8[7]}}, v8});
                    3'd1: wreg(rd, {{16{h[15]}}, h});
                    3'd2: wreg(rd, m[t[13:2]]);
                    3'd4: wreg(rd, {24'd0, v8});
                    3'd5: wreg(rd, {16'd0, h});
                    default: ;
                endcase
            end
            7'h23: begin
                t = a + is;
                case (f3)
                    3'd0: wr_b(t, b[7:0]);
                    3'd1: begin
                        wr_b({t[31:2], t[1], 1'b0}, b[7:0]);
                        wr_b({t[31:2], t[1], 1'b1}, b[15:8]);
                    end
                    3'd2: m[t[13:2]] = b;
                    default: ;
                endcase
            end
            7'h13: begin
                ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                if (ok) wreg(rd, ref_alu(f3, f3 == 3'd5 && f7 == 7'h20, a, ii));
            end
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                if (ok) wreg(rd, ref_alu(f3, f7 == 7'h20, a, b));
            end
            default: ;
        endcase
        exp_tr.push_back(pc);
        if (tk) exp_tr.push_back(pc + 32'd4);
        pc = nxt;
    endtask

    task automatic clr();
        for (int i = 0; i < 4096; i++) img[i] = 32'h0;
    endtask

    task automatic run_prog(input int cyc);
        for (int i = 0; i < 4096; i++) m[i] = img[i];
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        pc = 32'h0;
        exp_tr.delete();
        while (exp_tr.size() < cyc) iss_step();
        rst = 1'b1;
        for (int i = 0; i < 4096; i++) dut.i_Dcache.data[i] <= img[i];
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < cyc; k++) begin
            @(posedge clk);
            #1;
            tr[k] = dut.IFID_NowPC;
            chk($sformatf("trace[%0d]", k), tr[k], exp_tr[k]);
        end
        for (int i = 1; i < 32; i++) chk($sformatf("x%0d", i), dut.rf_q[i], r[i]);
        for (int w = 0; w < 512; w++) chk($sformatf("mem[%0d]", w), dut.i_Dcache.data[w], m[w]);
    endtask

    task automatic gen_rand(input int L);
        logic [4:0]  rd, s1, s2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int k;
        int bl [6] = '{0, 1, 4, 5, 6, 7};
        int ll [5] = '{0, 1, 2, 4, 5};
        for (int i = 0; i < 8; i++) img[i] = enc_u(7'h37, 5'(i + 1), 20'($urandom()));
        for (int i = 8; i < 16; i++) img[i] = addi(5'(i - 7), 5'(i - 7), 12'($urandom()));
        for (int i = 16; i < L; i++) begin
            rd  = 5'($urandom_range(0, 15));
            s1  = 5'($urandom_range(0, 15));
            s2  = 5'($urandom_range(0, 15));
            f3  = 3'($urandom());
            imm = 12'($urandom());
            k   = $urandom_range(0, 15);
            if (k <= 4) begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                img[i] = enc_i(7'h13, rd, f3, s1, imm);
            end else if (k <= 8) begin
                img[i] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                               ? 7'h20 : 7'h00, s2, s1, f3, rd);
            end else if (k == 9) begin
                img[i] = enc_u(($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17, rd, 20'($urandom()));
            end else if (k == 10) begin
                img[i] = enc_s(12'(12'h600 + $urandom_range(0, 511)), s2, 5'd0,
                               3'($urandom_range(0, 2)));
            end else if (k == 11) begin
                img[i] = enc_i(7'h03, rd, 3'(ll[$urandom_range(0, 4)]), 5'd0,
                               12'(12'h600 + $urandom_range(0, 511)));
            end else if (k <= 13 && i + 3 <= L) begin
                img[i] = enc_b(($urandom_range(0, 1) == 1) ? 13'd8 : 13'd12, s2, s1,
                               3'(bl[$urandom_range(0, 5)]));
            end else if (k == 14 && i + 2 <= L) begin
                img[i] = enc_j(rd, 21'd8);
            end else if (k == 15) begin
                case ($urandom_range(0, 2))
                    0: img[i] = 32'h0000_000F;
                    1: img[i] = 32'h0000_0073;
                    default: img[i] = 32'hFFFF_FFFF;
                endcase
            end else begin
                img[i] = NOP;
            end
        end
        img[L] = HALT;
        for (int w = 384; w < 512; w++) img[w] = $urandom();
    endtask

    initial begin
        int hit;
        int seen_fail;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pc", dut.pc_q, 32'h0);
        chk("rst_nowpc", dut.IFID_NowPC, 32'h0);
        chk("rst_instr", dut.IFID_Instr, NOP);

        // ALU chain, then an asynchronous reset in the middle of a cycle
        clr();
        img[0] = addi(5'd1, 5'd0, 12'd5);
        img[1] = addi(5'd2, 5'd0, 12'hFFD);
        img[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        img[3] = enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd4);
        img[4] = enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd5);
        img[5] = HALT;
        run_prog(20);
        chk("alu_add", dut.rf_q[3], 32'd2);
        chk("alu_sltu", dut.rf_q[4], 32'd0);
        chk("alu_sra", dut.rf_q[5], 32'hFFFF_FFFF);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_nowpc", dut.IFID_NowPC, 32'h0);
        chk("mid_rst_pc", dut.pc_q, 32'h0);
        for (int i = 1; i < 32; i++) chk($sformatf("mid_rst_x%0d", i), dut.rf_q[i], 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_pc%0d", k), dut.IFID_NowPC, 32'(4 * k));
        end
        repeat (12) @(posedge clk);
        #1;
        chk("rerun_add", dut.rf_q[3], 32'd2);
        chk("rerun_sra", dut.rf_q[5], 32'hFFFF_FFFF);

        // taken branch squashes the fetched slot
        clr();
        for (int i = 0; i < 4; i++) img[i] = addi(5'(i + 1), 5'd0, 12'(i + 1));
        img[4] = enc_b(13'd12, 5'd0, 5'd0, 3'd0);
        img[5] = addi(5'd6, 5'd0, 12'd99);
        img[6] = addi(5'd7, 5'd0, 12'd55);
        img[7] = addi(5'd8, 5'd0, 12'd7);
        img[8] = HALT;
        run_prog(20);
        chk("br_slot", tr[4], 32'h10);
        chk("br_bubble", tr[5], 32'h14);
        chk("br_target", tr[6], 32'h1C);
        chk("br_skip_x6", dut.rf_q[6], 32'h0);
        chk("br_tgt_x8", dut.rf_q[8], 32'd7);

        // byte/half/word memory lanes
        clr();
        img[0] = enc_u(7'h37, 5'd1, 20'h80402);
        img[1] = addi(5'd1, 5'd1, 12'h010);
        img[2] = enc_s(12'h100, 5'd1, 5'd0, 3'd2);
        img[3] = enc_i(7'h03, 5'd2, 3'd0, 5'd0, 12'h103);
        img[4] = enc_i(7'h03, 5'd3, 3'd5, 5'd0, 12'h102);
        img[5] = addi(5'd4, 5'd0, 12'h0AA);
        img[6] = enc_s(12'h101, 5'd4, 5'd0, 3'd0);
        img[7] = HALT;
        run_prog(20);
        chk("lb_sext", dut.rf_q[2], 32'hFFFF_FF80);
        chk("lhu_zext", dut.rf_q[3], 32'h0000_8040);
        chk("sb_merge", dut.i_Dcache.data[64], 32'h8040_AA10);

        // JAL link and JALR with bit 0 of the target cleared
        clr();
        for (int i = 0; i < 16; i++) img[i] = NOP;
        img[16] = enc_j(5'd1, 21'd8);
        img[17] = HALT;
        img[18] = enc_i(7'h67, 5'd0, 3'd0, 5'd1, 12'd1);
        run_prog(30);
        chk("jal_link", dut.rf_q[1], 32'h44);
        chk("jal_bubble", tr[17], 32'h44);
        chk("jal_next", tr[18], 32'h48);
        chk("jalr_tgt", tr[20], 32'h44);

        // self-test image: pass at 0x224, fail at 0x210
        clr();
        img[0]  = addi(5'd1, 5'd0, 12'd7);
        img[1]  = enc_i(7'h13, 5'd2, 3'd1, 5'd1, 12'd3);
        img[2]  = addi(5'd3, 5'd0, 12'd56);
        img[3]  = enc_b(13'h204, 5'd3, 5'd2, 3'd1);
        img[4]  = addi(5'd4, 5'd0, 12'hFFF);
        img[5]  = enc_b(13'h1FC, 5'd1, 5'd4, 3'd6);
        img[6]  = enc_b(13'h1F8, 5'd0, 5'd4, 3'd5);
        img[7]  = enc_s(12'h300, 5'd4, 5'd0, 3'd2);
        img[8]  = enc_i(7'h03, 5'd5, 3'd1, 5'd0, 12'h302);
        img[9]  = enc_b(13'h1EC, 5'd4, 5'd5, 3'd1);
        img[10] = enc_j(5'd0, 21'h1FC);
        img[132] = HALT;
        for (int i = 137; i < 144; i++) img[i] = addi(5'd6, 5'd6, 12'd1);
        img[144] = HALT;
        run_prog(40);
        hit = -1;
        seen_fail = 0;
        for (int k = 0; k < 40; k++) begin
            if (tr[k] == 32'h210) seen_fail = 1;
            if (hit < 0 && tr[k] == 32'h224) hit = k;
        end
        chk("fail_addr_seen", 32'(seen_fail), 32'd0);
        chk("pass_reached", (hit >= 0 && hit < 30) ? 32'd1 : 32'd0, 32'd1);
        if (hit >= 0 && hit < 30) begin
            chk("pass_step1", tr[hit + 1], 32'h228);
            chk("pass_step2", tr[hit + 2], 32'h22C);
        end

        for (int p = 0; p < 20; p++) begin
            clr();
            gen_rand(48);
            run_prog(3 * 48 + 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
